frame_buf_arbiter: RTL and testbench

FRAME_BUF_ARBITER -- requirements
Module: frame_buf_arbiter

---
 rtl/frame_buf_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_frame_buf_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_arbiter.sv
// Frame-buffer arbiter: shares one burst memory port between a camera writer
// and a VGA reader. Camera frames rotate through NUM_BUFS buffers; the reader
// always shows the most recently completed frame, repeating its current one
// when nothing newer is ready. Under contention VGA wins up to VGA_WEIGHT
// grants in a row before the camera is served.
module frame_buf_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int BURST_STEP   = 32,
  parameter int FRAME_BURSTS = 9600,
  parameter int NUM_BUFS     = 3,
  parameter int VGA_WEIGHT   = 3
) (
  input  logic              clk80,
  input  logic              rst,
  input  logic              cam_req,
  input  logic              vga_req,
  input  logic              Done,
  output logic              Go,
  output logic              Wr,
  output logic [ADDR_W-1:0] brst_Addr,
  output logic              vga_rst,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf,
  output logic              frame_drop
);

  localparam int OFF_W = $clog2(FRAME_BURSTS);
  localparam int CNT_W = $clog2(VGA_WEIGHT + 1);

  localparam logic [OFF_W-1:0]  LAST_OFF   = OFF_W'(FRAME_BURSTS - 1);
  localparam logic [ADDR_W-1:0] FRAME_SPAN = ADDR_W'(FRAME_BURSTS * BURST_STEP);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_STEP);
  localparam logic [CNT_W-1:0]  WEIGHT     = CNT_W'(VGA_WEIGHT);
  localparam logic [1:0]        LAST_BUF   = 2'(NUM_BUFS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             cam_q;
  logic             vga_q;
  logic             grant;
  logic             grant_cam;
  logic [OFF_W-1:0] wr_off;
  logic [OFF_W-1:0] rd_off;
  logic [CNT_W-1:0] vga_cnt;
  logic [1:0]       latest;
  logic             new_frame;
  logic             drop_pend;
  logic             init_done;
  logic [1:0]       next_wr_buf;
  logic [1:0]       skip_one;

  // Buffer index successor, wrapping at NUM_BUFS.
  function automatic logic [1:0] buf_inc(input logic [1:0] b);
    return (b == LAST_BUF) ? 2'd0 : b + 2'd1;
  endfunction

  // Start address of burst 'off' inside buffer 'b'; arithmetic wraps at ADDR_W.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [1:0] b,
                                                   input logic [OFF_W-1:0] off);
    return ADDR_W'(b) * FRAME_SPAN + ADDR_W'(off) * STEP;
  endfunction

  // Next write buffer: the one after wr_buf, stepping over the buffer on screen.
  // With two buffers this can land back on wr_buf, which means a drop is coming.
  assign skip_one    = buf_inc(wr_buf);
  assign next_wr_buf = (skip_one != rd_buf) ? skip_one : buf_inc(skip_one);

  // Requests are registered once before the arbiter looks at them.
  always_ff @(posedge clk80) begin
    // NOTE: every clocked assignment is non-blocking so all flops update
    // together from pre-edge values, independent of statement order.
    if (rst) begin
      cam_q <= 1'b0;
      vga_q <= 1'b0;
    end else begin
      cam_q <= cam_req;
      vga_q <= vga_req;
    end
  end

  // Burst sequencer state register.
  always_ff @(posedge clk80) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Arbitration, next state and the Go strobe.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and infers a latch.
    next_state = state;
    Go         = 1'b0;
    grant      = 1'b0;
    grant_cam  = 1'b0;
    case (state)
      IDLE: begin
        if (!init_done) begin
          grant     = cam_q;
          grant_cam = cam_q;
        end else if (cam_q && vga_q) begin
          grant     = 1'b1;
          grant_cam = (vga_cnt == WEIGHT);
        end else begin
          grant     = cam_q | vga_q;
          grant_cam = cam_q;
        end
        if (grant) next_state = ISSUE;
      end
      ISSUE: begin
        Go         = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (Done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Burst command, fairness counter, frame pointers and init tracking.
  always_ff @(posedge clk80) begin
    if (rst) begin
      Wr         <= 1'b0;
      brst_Addr  <= '0;
      vga_rst    <= 1'b1;
      wr_buf     <= 2'd0;
      rd_buf     <= 2'd0;
      frame_drop <= 1'b0;
      wr_off     <= '0;
      rd_off     <= '0;
      vga_cnt    <= '0;
      latest     <= 2'd0;
      new_frame  <= 1'b0;
      drop_pend  <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      frame_drop <= 1'b0;

      if (state == IDLE && grant) begin
        Wr        <= grant_cam;
        brst_Addr <= grant_cam ? burst_addr(wr_buf, wr_off)
                               : burst_addr(rd_buf, rd_off);
        if (grant_cam) begin
          vga_cnt <= '0;
          // The frame left in the buffer being rewritten is lost if unread.
          if (drop_pend) begin
            frame_drop <= new_frame;
            new_frame  <= 1'b0;
            drop_pend  <= 1'b0;
          end
        end else if (vga_cnt != WEIGHT) begin
          vga_cnt <= vga_cnt + 1'b1;
        end
      end

      if (state == WAIT && Done) begin
        if (Wr) begin
          if (wr_off == LAST_OFF) begin
            wr_off    <= '0;
            latest    <= wr_buf;
            new_frame <= 1'b1;
            wr_buf    <= next_wr_buf;
            drop_pend <= (next_wr_buf == wr_buf);
            init_done <= 1'b1;
            vga_rst   <= 1'b0;
          end else begin
            wr_off <= wr_off + 1'b1;
          end
        end else begin
          if (rd_off == LAST_OFF) begin
            rd_off <= '0;
            if (new_frame) begin
              rd_buf    <= latest;
              new_frame <= 1'b0;
            end
          end else begin
            rd_off <= rd_off + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Bench for frame_buf_arbiter: two instances (three and two buffers) share
// stimulus; grants are identical in both, only addresses and pointers differ.
// A memory-controller stand-in returns Done five cycles after each Go.
module tb_frame_buf_arbiter;

  localparam int AW   = 23;
  localparam int STEP = 32;
  localparam int FB   = 4;
  localparam int W    = 3;

  logic          clk80 = 1'b0;
  logic          rst;
  logic          cam_req;
  logic          vga_req;
  logic          Done;
  logic          go_s      [2];
  logic          wr_s      [2];
  logic [AW-1:0] addr_s    [2];
  logic          vga_rst_s [2];
  logic [1:0]    wrb_s     [2];
  logic [1:0]    rdb_s     [2];
  logic          drop_s    [2];

  int checks = 0;
  int errors = 0;
  int drop_cnt [2] = '{0, 0};

  // Reference model: per-instance frame pointers, shared arbitration history.
  int nbufs [2] = '{3, 2};
  int m_wr_buf [2];
  int m_rd_buf [2];
  int m_latest [2];
  int m_nf     [2];
  int m_pend   [2];
  int m_wr_off [2];
  int m_rd_off [2];
  int m_init;
  int m_vcnt;

  frame_buf_arbiter #(.ADDR_W(AW), .BURST_STEP(STEP), .FRAME_BURSTS(FB),
                      .NUM_BUFS(3), .VGA_WEIGHT(W)) dut (
    .clk80(clk80), .rst(rst), .cam_req(cam_req), .vga_req(vga_req), .Done(Done),
    .Go(go_s[0]), .Wr(wr_s[0]), .brst_Addr(addr_s[0]), .vga_rst(vga_rst_s[0]),
    .wr_buf(wrb_s[0]), .rd_buf(rdb_s[0]), .frame_drop(drop_s[0]));

  frame_buf_arbiter #(.ADDR_W(AW), .BURST_STEP(STEP), .FRAME_BURSTS(FB),
                      .NUM_BUFS(2), .VGA_WEIGHT(W)) dut_nb2 (
    .clk80(clk80), .rst(rst), .cam_req(cam_req), .vga_req(vga_req), .Done(Done),
    .Go(go_s[1]), .Wr(wr_s[1]), .brst_Addr(addr_s[1]), .vga_rst(vga_rst_s[1]),
    .wr_buf(wrb_s[1]), .rd_buf(rdb_s[1]), .frame_drop(drop_s[1]));

  always #5 clk80 = ~clk80;

  always @(negedge clk80) begin
    for (int i = 0; i < 2; i++) if (drop_s[i] === 1'b1) drop_cnt[i]++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wr_buf[i] = 0; m_rd_buf[i] = 0; m_latest[i] = 0; m_nf[i] = 0;
      m_pend[i] = 0; m_wr_off[i] = 0; m_rd_off[i] = 0;
    end
    m_init = 0;
    m_vcnt = 0;
  endtask

  // First buffer after the write buffer that is not on screen; the write
  // buffer itself if every other buffer is taken.
  function automatic int pick_next(int i);
    for (int k = 1; k <= nbufs[i]; k++) begin
      int c;
      c = (m_wr_buf[i] + k) % nbufs[i];
      if (c != m_rd_buf[i]) return c;
    end
    return m_wr_buf[i];
  endfunction

  function automatic bit predict_cam(logic c, logic v);
    if (m_init == 0) return 1'b1;
    if (c && !v) return 1'b1;
    if (v && !c) return 1'b0;
    return (m_vcnt >= W);
  endfunction

  // One complete burst: wait for Go, compare command with the model, apply the
  // next request levels, return Done after five cycles, compare pointers.
  task automatic do_burst(input logic nc, input logic nv,
                          output logic saw_wr, output logic [AW-1:0] saw_addr);
    int n;
    bit kind;
    bit eof;
    int ea;
    logic [AW-1:0] ea_v;
    logic ed;
    saw_wr   = 1'bx;
    saw_addr = 'x;
    n = 0;
    while (go_s[0] !== 1'b1 && n < 60) begin
      @(negedge clk80);
      n++;
    end
    checks++;
    if (go_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL go_timeout: no Go after %0d cycles, expected one", n);
      return;
    end
    kind     = predict_cam(cam_req, vga_req);
    saw_wr   = wr_s[0];
    saw_addr = addr_s[0];
    for (int i = 0; i < 2; i++) begin
      ea   = kind ? (m_wr_buf[i] * FB * STEP + m_wr_off[i] * STEP)
                  : (m_rd_buf[i] * FB * STEP + m_rd_off[i] * STEP);
      ea_v = AW'(ea);
      ed   = (kind && m_pend[i] != 0 && m_nf[i] != 0);
      checks++;
      if (go_s[i] !== 1'b1) begin
        errors++; $display("FAIL go_sync[%0d]: got %b expected 1", i, go_s[i]);
      end
      checks++;
      if (wr_s[i] !== kind) begin
        errors++; $display("FAIL wr_dir[%0d]: got %b expected %b", i, wr_s[i], kind);
      end
      checks++;
      if (addr_s[i] !== ea_v) begin
        errors++; $display("FAIL addr[%0d]: got %0d expected %0d", i, addr_s[i], ea_v);
      end
      checks++;
      if (drop_s[i] !== ed) begin
        errors++; $display("FAIL drop_at_grant[%0d]: got %b expected %b", i, drop_s[i], ed);
      end
      if (kind && m_pend[i] != 0) begin
        m_nf[i]   = 0;
        m_pend[i] = 0;
      end
    end
    if (kind) m_vcnt = 0;
    else if (m_vcnt < W) m_vcnt++;

    @(negedge clk80);
    cam_req = nc;
    vga_req = nv;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (go_s[i] !== 1'b0 || drop_s[i] !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width[%0d]: Go=%b drop=%b expected 0 0", i, go_s[i], drop_s[i]);
      end
    end
    repeat (4) @(negedge clk80);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (vga_rst_s[i] !== (m_init == 0)) begin
        errors++; $display("FAIL vga_rst_pre[%0d]: got %b expected %b", i, vga_rst_s[i], m_init == 0);
      end
    end
    Done = 1'b1;
    @(negedge clk80);
    Done = 1'b0;

    eof = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (kind) begin
        if (m_wr_off[i] + 1 == FB) begin
          int nb;
          m_wr_off[i] = 0;
          m_latest[i] = m_wr_buf[i];
          m_nf[i]     = 1;
          nb          = pick_next(i);
          m_pend[i]   = (nb == m_wr_buf[i]) ? 1 : 0;
          m_wr_buf[i] = nb;
          eof         = 1'b1;
        end else begin
          m_wr_off[i]++;
        end
      end else begin
        if (m_rd_off[i] + 1 == FB) begin
          m_rd_off[i] = 0;
          if (m_nf[i] != 0) begin
            m_rd_buf[i] = m_latest[i];
            m_nf[i]     = 0;
          end
        end else begin
          m_rd_off[i]++;
        end
      end
    end
    if (eof) m_init = 1;

    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wrb_s[i] !== 2'(m_wr_buf[i]) || rdb_s[i] !== 2'(m_rd_buf[i])) begin
        errors++;
        $display("FAIL bufs[%0d]: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                 i, wrb_s[i], rdb_s[i], m_wr_buf[i], m_rd_buf[i]);
      end
      checks++;
      if (vga_rst_s[i] !== (m_init == 0)) begin
        errors++; $display("FAIL vga_rst_post[%0d]: got %b expected %b", i, vga_rst_s[i], m_init == 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (go_s[i] !== 1'b0 || wr_s[i] !== 1'b0 || addr_s[i] !== '0 || vga_rst_s[i] !== 1'b1 ||
          wrb_s[i] !== 2'd0 || rdb_s[i] !== 2'd0 || drop_s[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d]: got Go=%b Wr=%b addr=%0d vga_rst=%b wr=%0d rd=%0d drop=%b expected 0 0 0 1 0 0 0",
                 tag, i, go_s[i], wr_s[i], addr_s[i], vga_rst_s[i], wrb_s[i], rdb_s[i], drop_s[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cam_req = 1'b1; vga_req = 1'b1; Done = 1'b0;
    repeat (2) begin
      @(negedge clk80);
      check_reset_outputs("reset_values");
    end
    cam_req = 1'b0; vga_req = 1'b0;
    @(negedge clk80);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk80);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_init();
    logic w;
    logic [AW-1:0] a;
    vga_req = 1'b1;
    repeat (10) begin
      @(negedge clk80);
      checks++;
      if (go_s[0] !== 1'b0 || vga_rst_s[0] !== 1'b1) begin
        errors++; $display("FAIL vga_before_init: got Go=%b vga_rst=%b expected 0 1", go_s[0], vga_rst_s[0]);
      end
    end
    cam_req = 1'b1;
    for (int k = 0; k < FB; k++) begin
      do_burst(1'b1, 1'b1, w, a);
      checks++;
      if (w !== 1'b1 || a !== AW'(k * STEP)) begin
        errors++; $display("FAIL init_write%0d: got Wr=%b addr=%0d expected 1 %0d", k, w, a, k * STEP);
      end
    end
    checks++;
    if (wrb_s[0] !== 2'd1 || vga_rst_s[0] !== 1'b0) begin
      errors++; $display("FAIL init_done: got wr_buf=%0d vga_rst=%b expected 1 0", wrb_s[0], vga_rst_s[0]);
    end
  endtask

  task automatic test_weighting();
    logic exp_wr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic w;
    logic [AW-1:0] a;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) do_burst(1'b1, 1'b0, w, a);
      else        do_burst(1'b1, 1'b1, w, a);
      checks++;
      if (w !== exp_wr[k]) begin
        errors++; $display("FAIL weight_order%0d: got Wr=%b expected %b", k, w, exp_wr[k]);
      end
    end
  endtask

  task automatic test_repeat_switch();
    int exp_wa [2] = '{192, 224};
    int exp_ra [6] = '{64, 96, 128, 160, 192, 224};
    logic w;
    logic [AW-1:0] a;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) do_burst(1'b0, 1'b1, w, a);
      else        do_burst(1'b1, 1'b0, w, a);
      checks++;
      if (w !== 1'b1 || a !== AW'(exp_wa[k])) begin
        errors++; $display("FAIL cam_fill%0d: got Wr=%b addr=%0d expected 1 %0d", k, w, a, exp_wa[k]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 5) do_burst(1'b1, 1'b0, w, a);
      else        do_burst(1'b0, 1'b1, w, a);
      checks++;
      if (w !== 1'b0 || a !== AW'(exp_ra[k])) begin
        errors++; $display("FAIL vga_read%0d: got Wr=%b addr=%0d expected 0 %0d", k, w, a, exp_ra[k]);
      end
    end
    checks++;
    if (rdb_s[0] !== 2'd1) begin
      errors++; $display("FAIL rd_switch: got rd_buf=%0d expected 1", rdb_s[0]);
    end
  endtask

  task automatic test_skip();
    logic w;
    logic [AW-1:0] a;
    int d0;
    int d1;
    repeat (FB) do_burst(1'b1, 1'b0, w, a);
    checks++;
    if (wrb_s[0] !== 2'd0 || rdb_s[0] !== 2'd1) begin
      errors++; $display("FAIL wrap_wr: got wr=%0d rd=%0d expected 0 1", wrb_s[0], rdb_s[0]);
    end
    repeat (FB) do_burst(1'b1, 1'b0, w, a);
    checks++;
    if (wrb_s[0] !== 2'd2) begin
      errors++; $display("FAIL skip_rd_buf: got wr_buf=%0d expected 2", wrb_s[0]);
    end
    checks++;
    if (wrb_s[1] !== 2'd0 || rdb_s[1] !== 2'd1) begin
      errors++; $display("FAIL two_buf_stay: got wr=%0d rd=%0d expected 0 1", wrb_s[1], rdb_s[1]);
    end
    d0 = drop_cnt[0];
    d1 = drop_cnt[1];
    do_burst(1'b0, 1'b0, w, a);
    checks++;
    if (drop_cnt[1] - d1 != 1 || drop_cnt[0] - d0 != 0) begin
      errors++;
      $display("FAIL frame_drop: got pulses %0d/%0d expected 0/1", drop_cnt[0] - d0, drop_cnt[1] - d1);
    end
  endtask

  task automatic test_random();
    logic w;
    logic [AW-1:0] a;
    int p;
    logic nc;
    logic nv;
    p = $urandom_range(0, 2);
    cam_req = (p != 1);
    vga_req = (p != 0);
    for (int k = 0; k < 60; k++) begin
      p  = $urandom_range(0, 2);
      nc = (k == 59) ? 1'b0 : (p != 1);
      nv = (k == 59) ? 1'b0 : (p != 0);
      do_burst(nc, nv, w, a);
    end
  endtask

  task automatic test_mid_reset();
    logic w;
    logic [AW-1:0] a;
    int n;
    cam_req = 1'b1;
    n = 0;
    while (go_s[0] !== 1'b1 && n < 60) begin
      @(negedge clk80);
      n++;
    end
    checks++;
    if (go_s[0] !== 1'b1) begin
      errors++; $display("FAIL mid_go_timeout: no Go after %0d cycles, expected one", n);
    end
    repeat (2) @(negedge clk80);
    cam_req = 1'b0;
    rst     = 1'b1;
    @(negedge clk80);
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    @(negedge clk80);
    Done = 1'b1;
    @(negedge clk80);
    Done = 1'b0;
    repeat (2) @(negedge clk80);
    check_reset_outputs("stale_done");
    model_reset();
    cam_req = 1'b1;
    do_burst(1'b0, 1'b0, w, a);
    checks++;
    if (w !== 1'b1 || a !== '0) begin
      errors++; $display("FAIL restart_addr: got Wr=%b addr=%0d expected 1 0", w, a);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_weighting();
    test_repeat_switch();
    test_skip();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
